// File: rtl/id_stage.sv
// MIPS decode stage: register file with write-through, control decode,
// early branch/jump resolution and the flushable D->E pipeline register.
module id_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCPlus4D,
  input  logic        ForwardAD,
  input  logic        ForwardBD,
  input  logic [31:0] ALUOutM,
  input  logic        FlushE,
  input  logic        RegWriteW,
  input  logic [4:0]  WriteRegW,
  input  logic [31:0] ResultW,
  output logic [31:0] PCBranchD,
  output logic        PCSrcD,
  output logic [4:0]  RsD,
  output logic [4:0]  RtD,
  output logic        BranchD,
  output logic        RegWriteE,
  output logic        MemtoRegE,
  output logic        MemWriteE,
  output logic        ALUSrcE,
  output logic        RegDstE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] SignImmE,
  output logic [4:0]  RsE,
  output logic [4:0]  RtE,
  output logic [4:0]  RdE
);

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic        alu_src;
    logic        reg_dst;
    logic [2:0]  alu_ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] simm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } ereg_t;

  logic [31:0] rf_q [32];
  logic [4:0]  rd_idx;
  logic [31:0] simm, rd1, rd2, cmp_a, cmp_b;
  logic        wb_en;
  // ctrl bit order: RegWrite RegDst ALUSrc Branch MemWrite MemtoReg Jump
  logic [6:0]  ctrl;
  logic [2:0]  alu_ctrl;
  ereg_t       e_d, e_q;

  assign RsD    = InstrD[25:21];
  assign RtD    = InstrD[20:16];
  assign rd_idx = InstrD[15:11];
  assign simm   = {{16{InstrD[15]}}, InstrD[15:0]};
  assign wb_en  = RegWriteW && (WriteRegW != 5'd0);

  // $0 is never written, so its reset value keeps it at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_en) begin
      rf_q[WriteRegW] <= ResultW;
    end
  end

  always_comb begin
    rd1 = (RsD == 5'd0) ? '0 : (wb_en && WriteRegW == RsD) ? ResultW : rf_q[RsD];
    rd2 = (RtD == 5'd0) ? '0 : (wb_en && WriteRegW == RtD) ? ResultW : rf_q[RtD];
  end

  always_comb begin
    ctrl     = 7'b0000000;
    alu_ctrl = 3'b000;
    case (InstrD[31:26])
      6'b000000: begin
        ctrl = 7'b1100000;
        case (InstrD[5:0])
          6'b100000: alu_ctrl = 3'b010;
          6'b100010: alu_ctrl = 3'b110;
          6'b100100: alu_ctrl = 3'b000;
          6'b100101: alu_ctrl = 3'b001;
          6'b101010: alu_ctrl = 3'b111;
          default:   ctrl[6]  = 1'b0;
        endcase
      end
      6'b100011: begin ctrl = 7'b1010010; alu_ctrl = 3'b010; end
      6'b101011: begin ctrl = 7'b0010100; alu_ctrl = 3'b010; end
      6'b000100: begin ctrl = 7'b0001000; alu_ctrl = 3'b110; end
      6'b001000: begin ctrl = 7'b1010000; alu_ctrl = 3'b010; end
      6'b000010: ctrl = 7'b0000001;
      default:   ctrl = 7'b0000000;
    endcase
  end

  assign BranchD   = ctrl[3];
  assign cmp_a     = ForwardAD ? ALUOutM : rd1;
  assign cmp_b     = ForwardBD ? ALUOutM : rd2;
  assign PCSrcD    = (ctrl[3] && (cmp_a == cmp_b)) || ctrl[0];
  assign PCBranchD = ctrl[0] ? {PCPlus4D[31:28], InstrD[25:0], 2'b00}
                             : PCPlus4D + {simm[29:0], 2'b00};

  always_comb begin
    e_d = '0;
    if (!FlushE) begin
      e_d.reg_write  = ctrl[6];
      e_d.reg_dst    = ctrl[5];
      e_d.alu_src    = ctrl[4];
      e_d.mem_write  = ctrl[2];
      e_d.mem_to_reg = ctrl[1];
      e_d.alu_ctrl   = alu_ctrl;
      e_d.rd1        = rd1;
      e_d.rd2        = rd2;
      e_d.simm       = simm;
      e_d.rs         = RsD;
      e_d.rt         = RtD;
      e_d.rd         = rd_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) e_q <= '0;
    else        e_q <= e_d;
  end

  assign RegWriteE   = e_q.reg_write;
  assign MemtoRegE   = e_q.mem_to_reg;
  assign MemWriteE   = e_q.mem_write;
  assign ALUSrcE     = e_q.alu_src;
  assign RegDstE     = e_q.reg_dst;
  assign ALUControlE = e_q.alu_ctrl;
  assign RD1E        = e_q.rd1;
  assign RD2E        = e_q.rd2;
  assign SignImmE    = e_q.simm;
  assign RsE         = e_q.rs;
  assign RtE         = e_q.rt;
  assign RdE         = e_q.rd;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, write-through, $0, branch/jump, flush, decode.
module tb_id_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] InstrD, PCPlus4D, ALUOutM, ResultW;
  logic        ForwardAD, ForwardBD, FlushE, RegWriteW;
  logic [4:0]  WriteRegW;
  logic [31:0] PCBranchD, RD1E, RD2E, SignImmE;
  logic        PCSrcD, BranchD, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
  logic [4:0]  RsD, RtD, RsE, RtE, RdE;
  logic [2:0]  ALUControlE;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst_n(rst_n), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .ALUOutM(ALUOutM),
    .FlushE(FlushE), .RegWriteW(RegWriteW), .WriteRegW(WriteRegW),
    .ResultW(ResultW), .PCBranchD(PCBranchD), .PCSrcD(PCSrcD),
    .RsD(RsD), .RtD(RtD), .BranchD(BranchD), .RegWriteE(RegWriteE),
    .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
    .RegDstE(RegDstE), .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E),
    .SignImmE(SignImmE), .RsE(RsE), .RtE(RtE), .RdE(RdE)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    InstrD = '0; PCPlus4D = '0; ForwardAD = 0; ForwardBD = 0; ALUOutM = '0;
    FlushE = 0; RegWriteW = 0; WriteRegW = '0; ResultW = '0;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] v);
    idle();
    RegWriteW = 1; WriteRegW = r; ResultW = v;
    tick();
    RegWriteW = 0;
  endtask

  task automatic test_reset();
    logic [8:0] ctl;
    idle();
    rst_n = 0;
    tick(); tick();
    ctl = {RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE, 1'b0};
    checks++;
    if (ctl !== 9'h0 || RD1E !== 0 || RD2E !== 0 || SignImmE !== 0 || RdE !== 0) begin
      errors++; $display("FAIL reset_init ctl=%h rd1=%h rd2=%h imm=%h exp all 0", ctl, RD1E, RD2E, SignImmE);
    end
    #2 rst_n = 1;
    // Write $7 while reading it (rs=7, add $0,$7,$0)
    InstrD = 32'h00E00020; RegWriteW = 1; WriteRegW = 5'd7; ResultW = 32'h77;
    tick();
    RegWriteW = 0;
    tick();
    checks++;
    if (RD1E !== 32'h77 || RegWriteE !== 1'b1) begin
      errors++; $display("FAIL reset_pre rd1=%h rw=%b exp 77 1", RD1E, RegWriteE);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (RD1E !== 0 || RegWriteE !== 0 || ALUControlE !== 0 || RsE !== 0 || SignImmE !== 0) begin
      errors++; $display("FAIL reset_async rd1=%h rw=%b alu=%b rs=%h exp 0", RD1E, RegWriteE, ALUControlE, RsE);
    end
    #1 rst_n = 1;
    tick();
    checks++;
    if (RD1E !== 0) begin
      errors++; $display("FAIL reset_rf_cleared rd1=%h exp 0", RD1E);
    end
  endtask

  task automatic test_bypass();
    idle();
    InstrD = 32'h00A01820; RegWriteW = 1; WriteRegW = 5'd5; ResultW = 32'h00001234;
    tick();
    checks++;
    if (RD1E !== 32'h1234 || RdE !== 5'd3 || RegDstE !== 1 || ALUControlE !== 3'b010 ||
        RegWriteE !== 1 || RD2E !== 0 || RsE !== 5'd5) begin
      errors++; $display("FAIL bypass rd1=%h rd=%0d rdst=%b alu=%b rw=%b rd2=%h exp 1234 3 1 010 1 0",
                         RD1E, RdE, RegDstE, ALUControlE, RegWriteE, RD2E);
    end
    // Operand on rt: sub $4,$0,$5 reads stored $5
    idle(); InstrD = 32'h00052022;
    tick();
    checks++;
    if (RD2E !== 32'h1234 || ALUControlE !== 3'b110 || RdE !== 5'd4) begin
      errors++; $display("FAIL rf_read_rt rd2=%h alu=%b rd=%0d exp 1234 110 4", RD2E, ALUControlE, RdE);
    end
  endtask

  task automatic test_zero_reg();
    idle();
    InstrD = 32'h00001820; RegWriteW = 1; WriteRegW = 5'd0; ResultW = 32'hFFFFFFFF;
    tick();
    checks++;
    if (RD1E !== 0 || RD2E !== 0) begin
      errors++; $display("FAIL zero_bypass rd1=%h rd2=%h exp 0", RD1E, RD2E);
    end
    RegWriteW = 0;
    tick();
    checks++;
    if (RD1E !== 0) begin
      errors++; $display("FAIL zero_stored rd1=%h exp 0", RD1E);
    end
  endtask

  task automatic test_branch();
    wb(5'd1, 32'd7);
    wb(5'd2, 32'd7);
    idle();
    InstrD = 32'h10220003; PCPlus4D = 32'h100;
    #1;
    checks++;
    if (PCSrcD !== 1 || PCBranchD !== 32'h10C || BranchD !== 1 || RsD !== 5'd1 || RtD !== 5'd2) begin
      errors++; $display("FAIL beq_taken src=%b tgt=%h br=%b exp 1 10c 1", PCSrcD, PCBranchD, BranchD);
    end
    ForwardAD = 1; ALUOutM = 32'd8;
    #1;
    checks++;
    if (PCSrcD !== 0 || PCBranchD !== 32'h10C) begin
      errors++; $display("FAIL beq_fwd_a src=%b tgt=%h exp 0 10c", PCSrcD, PCBranchD);
    end
    ForwardBD = 1;
    #1;
    checks++;
    if (PCSrcD !== 1) begin
      errors++; $display("FAIL beq_fwd_ab src=%b exp 1", PCSrcD);
    end
    ForwardAD = 0; ForwardBD = 0; InstrD = 32'h1022FFFF;
    #1;
    checks++;
    if (PCSrcD !== 1 || PCBranchD !== 32'hFC) begin
      errors++; $display("FAIL beq_neg src=%b tgt=%h exp 1 fc", PCSrcD, PCBranchD);
    end
    tick();
    checks++;
    if (RegWriteE !== 0 || ALUControlE !== 3'b110 || SignImmE !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL beq_ereg rw=%b alu=%b imm=%h exp 0 110 ffffffff", RegWriteE, ALUControlE, SignImmE);
    end
  endtask

  task automatic test_jump();
    idle(); InstrD = 32'h00221820; // add $3,$1,$2
    tick();
    checks++;
    if (RegWriteE !== 1 || RD1E !== 32'd7 || RD2E !== 32'd7) begin
      errors++; $display("FAIL add_pre rw=%b rd1=%h rd2=%h exp 1 7 7", RegWriteE, RD1E, RD2E);
    end
    InstrD = 32'h08000040; PCPlus4D = 32'h10000004;
    #1;
    checks++;
    if (PCSrcD !== 1 || PCBranchD !== 32'h10000100 || BranchD !== 0) begin
      errors++; $display("FAIL jump src=%b tgt=%h br=%b exp 1 10000100 0", PCSrcD, PCBranchD, BranchD);
    end
    tick();
    checks++;
    if (RegWriteE !== 0) begin
      errors++; $display("FAIL jump_rw rw=%b exp 0", RegWriteE);
    end
  endtask

  task automatic test_flush_illegal();
    idle(); InstrD = 32'h8C230004; FlushE = 1;
    tick();
    checks++;
    if (RegWriteE !== 0 || MemtoRegE !== 0 || RD1E !== 0 || SignImmE !== 0 || RsE !== 0) begin
      errors++; $display("FAIL flush_lw rw=%b m2r=%b rd1=%h imm=%h exp 0", RegWriteE, MemtoRegE, RD1E, SignImmE);
    end
    FlushE = 0;
    tick();
    checks++;
    if (RegWriteE !== 1 || MemtoRegE !== 1 || ALUSrcE !== 1 || RegDstE !== 0 || RD1E !== 32'd7 ||
        SignImmE !== 32'd4 || RtE !== 5'd3 || ALUControlE !== 3'b010) begin
      errors++; $display("FAIL lw rw=%b m2r=%b src=%b dst=%b rd1=%h imm=%h rt=%0d", RegWriteE, MemtoRegE,
                         ALUSrcE, RegDstE, RD1E, SignImmE, RtE);
    end
    InstrD = 32'hFC000000;
    tick();
    checks++;
    if ({RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE} !== 8'h0) begin
      errors++; $display("FAIL illegal ctl=%b exp 0", {RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE});
    end
    InstrD = 32'hAC220008; // sw $2,8($1)
    tick();
    checks++;
    if (MemWriteE !== 1 || RegWriteE !== 0 || ALUSrcE !== 1 || ALUControlE !== 3'b010 || RD2E !== 32'd7) begin
      errors++; $display("FAIL sw mw=%b rw=%b src=%b alu=%b rd2=%h", MemWriteE, RegWriteE, ALUSrcE, ALUControlE, RD2E);
    end
    InstrD = 32'h2023FFFE; // addi $3,$1,-2
    tick();
    checks++;
    if (RegWriteE !== 1 || ALUSrcE !== 1 || RegDstE !== 0 || SignImmE !== 32'hFFFFFFFE || ALUControlE !== 3'b010) begin
      errors++; $display("FAIL addi rw=%b src=%b dst=%b imm=%h alu=%b", RegWriteE, ALUSrcE, RegDstE, SignImmE, ALUControlE);
    end
  endtask

  task automatic test_funct();
    logic [5:0] fn [5];
    logic [2:0] ac [5];
    fn = '{6'h24, 6'h25, 6'h2A, 6'h20, 6'h22};
    ac = '{3'b000, 3'b001, 3'b111, 3'b010, 3'b110};
    idle();
    for (int i = 0; i < 5; i++) begin
      InstrD = {6'b0, 5'd1, 5'd2, 5'd3, 5'd0, fn[i]};
      tick();
      checks++;
      if (ALUControlE !== ac[i] || RegWriteE !== 1) begin
        errors++; $display("FAIL funct_%h alu=%b rw=%b exp %b 1", fn[i], ALUControlE, RegWriteE, ac[i]);
      end
    end
    InstrD = {6'b0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h27};
    tick();
    checks++;
    if (RegWriteE !== 0) begin
      errors++; $display("FAIL funct_unknown rw=%b exp 0", RegWriteE);
    end
  endtask

  initial begin
    rst_n = 0;
    idle();
    test_reset();
    test_bypass();
    test_zero_reg();
    test_branch();
    test_jump();
    test_flush_illegal();
    test_funct();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage of the 5-stage MIPS pipeline; directly downstream of the fetch stage.
- Consumes InstrD/PCPlus4D from fetch and returns PCBranchD/PCSrcD (early branch/jump resolution in D).
- Holds the 32x32 register file, which is written from WB.
- Contains the main/ALU control decoder and the D→E pipeline register (flushable by the hazard unit).

Parameters:
- none (32-bit MIPS datapath, 32 registers, fixed)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- InstrD  in  32  instruction from fetch
- PCPlus4D  in  32  PC+4 from fetch
- ForwardAD  in  1  branch operand A: select ALUOutM instead of RD1
- ForwardBD  in  1  branch operand B: select ALUOutM instead of RD2
- ALUOutM  in  32  M-stage ALU result for branch forwarding
- FlushE  in  1  load bubble into E register
- RegWriteW  in  1  writeback enable
- WriteRegW  in  5  writeback register index
- ResultW  in  32  writeback data
- PCBranchD  out  32  branch or jump target to fetch
- PCSrcD  out  1  redirect fetch
- RsD, RtD  out  5 each  source indices for hazard unit
- BranchD  out  1  decoded beq, for hazard unit
- RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE  out  1 each  registered controls
- ALUControlE  out  3  registered ALU op
- RD1E, RD2E, SignImmE  out  32 each  registered operands and immediate
- RsE, RtE, RdE  out  5 each  registered register indices

Behaviour:
- Reset: rst_n=0 asynchronously clears all 32 registers and every E output to 0. It takes effect mid-operation regardless of clk.
- Register file:
  - Write on posedge clk when RegWriteW=1 and WriteRegW!=0. Writes to $0 are dropped; $0 always reads 0.
  - Reads are combinational with write-through: if RegWriteW=1, WriteRegW!=0 and WriteRegW equals the read index, the read returns ResultW in the same cycle.
- Decode (combinational):
  - RsD=InstrD[25:21], RtD=InstrD[20:16], RdD=InstrD[15:11].
  - SignImmD = sign-extension of InstrD[15:0].
- Opcode → control {RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemtoReg, Jump}:
  - 000000 R: 1100000, ALUControl from funct.
  - 100011 lw: 1010010, add.
  - 101011 sw: 0010100, add.
  - 000100 beq: 0001000, sub.
  - 001000 addi: 1010000, add.
  - 000010 j: 0000001.
  - Any other opcode: all controls 0, ALUControl 000 (bubble).
- Funct → ALUControl: 100000 add=010; 100010 sub=110; 100100 and=000; 100101 or=001; 101010 slt=111. Unknown funct: RegWrite forced 0.
- Branch/jump (combinational, zero-cycle latency):
  - A = ForwardAD ? ALUOutM : RD1; B = ForwardBD ? ALUOutM : RD2; EqualD = (A==B).
  - PCSrcD = (BranchD & EqualD) | Jump.
  - Jump: PCBranchD = {PCPlus4D[31:28], InstrD[25:0], 2'b00}.
  - Otherwise: PCBranchD = PCPlus4D + (SignImmD<<2), mod 2^32 (wraps, no overflow flag).
- E register (posedge clk, 1-cycle latency):
  - Normally loads all decoded fields.
  - FlushE=1 loads all control and data outputs as 0.
  - FlushE has priority over new data.
  - WB register-file writes proceed in the same cycle regardless of FlushE.
- No stall input: a D stall is handled by fetch holding InstrD while the hazard unit asserts FlushE.

Test Plan:
- Reset → with rst_n=0 asserted mid-cycle, all E outputs = 0 immediately; after release, a read of any register (e.g. $7) gives RD1E=0.
- Bypass → RegWriteW=1, WriteRegW=5, ResultW=0x00001234, InstrD=0x00A01820 (add $3,$5,$0) → after edge RD1E=0x1234, RdE=3, RegDstE=1, ALUControlE=010, RegWriteE=1.
- $0 write → WriteRegW=0, ResultW=0xFFFFFFFF, RegWriteW=1, then read $0 → RD1E=0.
- beq taken, forwarded and negative offset:
  - $1=$2=7, InstrD=0x10220003, PCPlus4D=0x100 → same cycle PCSrcD=1, PCBranchD=0x10C.
  - ForwardAD=1, ALUOutM=8 → PCSrcD=0.
  - imm=0xFFFF → PCBranchD=0xFC.
- Jump → InstrD=0x08000040, PCPlus4D=0x10000004 → PCSrcD=1, PCBranchD=0x10000100, RegWriteE=0 after edge.
- Flush/illegal:
  - lw 0x8C230004 with FlushE=1 → after edge RegWriteE=MemtoRegE=0, RD1E=0.
  - Opcode 0x3F with FlushE=0 → all E controls 0.
